// File: rtl/conv_feed_pkg.sv
// -----------------------------------------------------------------------------
// conv_feed_pkg
// Shared types and constants for the 3x3 convolution window feeder.
//   state_e      : feeder FSM states (IDLE, FILL, STREAM, PAD, DONE)
//   IMG_W/KER_W  : default pixel / weight widths
//   N_ROWS       : rows per packed column, N_TAPS : slots per window
//   *_ROW_OFS    : bit offset of each row inside a 24-bit input column
//   MIN_LEN      : smallest column count that produces any window
//   FILL_COLS    : accepted columns before the first window can form
// Optional feature macro: WINDOW_ZERO_PAD_EN (zero column before/after job).
// -----------------------------------------------------------------------------
package conv_feed_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        PAD    = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int IMG_W  = 8;
    localparam int KER_W  = 4;
    localparam int N_ROWS = 3;
    localparam int N_TAPS = 9;

    localparam int IMG_ROW_OFS [N_ROWS] = '{0, 8, 16};
    localparam int KER_ROW_OFS [N_ROWS] = '{0, 8, 16};

`ifdef WINDOW_ZERO_PAD_EN
    // A zero column is preloaded at start, so one real column completes FILL.
    localparam int MIN_LEN   = 1;
    localparam int FILL_COLS = 1;
`else
    localparam int MIN_LEN   = 3;
    localparam int FILL_COLS = 2;
`endif

endpackage

// File: rtl/conv_window_feeder_tap_shift3.sv
// -----------------------------------------------------------------------------
// tap_shift3
// Three-deep shift register for one window row.
//   clk, i_rst : clock, synchronous active-high reset
//   i_clr      : synchronous clear (job start), wins over i_en
//   i_en       : shift i_d in as the newest tap
//   i_d        : incoming sample
//   o_taps     : [W-1:0] oldest, [2W-1:W] middle, [3W-1:2W] newest
// -----------------------------------------------------------------------------
module tap_shift3 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           i_rst,
    input  logic           i_clr,
    input  logic           i_en,
    input  logic [W-1:0]   i_d,
    output logic [3*W-1:0] o_taps
);

    logic [3*W-1:0] taps_q;
    logic [3*W-1:0] taps_d;

    always_comb begin
        taps_d = taps_q;
        if (i_clr) begin
            taps_d = '0;
        end else if (i_en) begin
            // Oldest drops off the low end, new sample enters at the top.
            taps_d = {i_d, taps_q[3*W-1:W]};
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign o_taps = taps_q;

endmodule

// File: rtl/conv_window_feeder.sv
// -----------------------------------------------------------------------------
// conv_window_feeder
// Shifts packed 3-row image/weight columns into a 3-column window and presents
// 9 pixels + 9 weights with a valid strobe to the 3x3 MAC.
//   clk, i_rst           : clock, synchronous active-high reset
//   i_start, i_len       : job start (sampled in IDLE), column count
//   i_valid / o_ready    : column transfer, accepted when both are high
//   i_img, i_wgt         : packed columns (rows at bit offsets 0/8/16)
//   i_inhibit            : downstream stall, freezes the whole block
//   o_valid              : window valid
//   o_im_win, o_ker_win  : slot k at [k*W-1:(k-1)*W]; 1..3 row1 oldest..newest
//   o_busy, o_done       : not IDLE, one-cycle completion pulse
//   o_win_cnt            : windows emitted in the current/last job
// Handshake: a column moves on a clock edge iff i_valid && o_ready; o_ready is
// high only in FILL/STREAM with i_inhibit low, and never depends on i_valid.
// Optional feature macro: WINDOW_ZERO_PAD_EN (adds PAD state, i_len windows).
// -----------------------------------------------------------------------------
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int KER_W = 4,
    parameter int LEN_W = 17
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_len,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [23:0]        i_img,
    input  logic [23:0]        i_wgt,
    input  logic               i_inhibit,
    output logic               o_valid,
    output logic [9*IMG_W-1:0] o_im_win,
    output logic [9*KER_W-1:0] o_ker_win,
    output logic               o_busy,
    output logic               o_done,
    output logic [LEN_W-1:0]   o_win_cnt
);

    import conv_feed_pkg::state_e;
    import conv_feed_pkg::IDLE;
    import conv_feed_pkg::FILL;
    import conv_feed_pkg::STREAM;
    import conv_feed_pkg::PAD;
    import conv_feed_pkg::DONE;
    import conv_feed_pkg::N_ROWS;
    import conv_feed_pkg::IMG_ROW_OFS;
    import conv_feed_pkg::KER_ROW_OFS;
    import conv_feed_pkg::MIN_LEN;
    import conv_feed_pkg::FILL_COLS;

`ifdef WINDOW_ZERO_PAD_EN
    localparam state_e LAST_ST = PAD;
`else
    localparam state_e LAST_ST = DONE;
`endif

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] col_cnt_q, col_cnt_d;
    logic [LEN_W-1:0] win_cnt_q, win_cnt_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] col_next;

    logic accept;
    logic win_clr;
    logic shift_en;
    logic shift_zero;

    // Weight nibbles between the row fields carry no information.
    logic unused_wgt;
    assign unused_wgt = ^{i_wgt[23:20], i_wgt[15:12], i_wgt[7:4]};

    // State register and counters; i_inhibit is folded into the _d logic.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            col_cnt_q <= '0;
            win_cnt_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            col_cnt_q <= col_cnt_d;
            win_cnt_q <= win_cnt_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Next-state and counter logic. Everything holds while inhibited.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        col_cnt_d = col_cnt_q;
        win_cnt_d = win_cnt_q;
        valid_d   = valid_q;
        done_d    = done_q;
        col_next  = col_cnt_q + LEN_W'(1);
        if (!i_inhibit) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        len_d     = i_len;
                        col_cnt_d = '0;
                        win_cnt_d = '0;
                        state_d   = (i_len >= LEN_W'(MIN_LEN)) ? FILL : DONE;
                    end
                end
                FILL: begin
                    if (accept) begin
                        col_cnt_d = col_next;
                        if (col_next == len_q) begin
                            state_d = LAST_ST;
                        end else if (col_next == LEN_W'(FILL_COLS)) begin
                            state_d = STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        col_cnt_d = col_next;
                        valid_d   = 1'b1;
                        win_cnt_d = win_cnt_q + LEN_W'(1);
                        if (col_next == len_q) begin
                            state_d = LAST_ST;
                        end
                    end
                end
`ifdef WINDOW_ZERO_PAD_EN
                PAD: begin
                    // Trailing zero column completes the last window.
                    valid_d   = 1'b1;
                    win_cnt_d = win_cnt_q + LEN_W'(1);
                    state_d   = DONE;
                end
`endif
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs and datapath controls decoded from the current state.
    always_comb begin
        o_ready    = ((state_q == FILL) || (state_q == STREAM)) && !i_inhibit;
        o_busy     = (state_q != IDLE);
        accept     = i_valid && o_ready;
        shift_zero = (state_q == PAD);
        shift_en   = accept || (shift_zero && !i_inhibit);
        // Clearing on every accepted start doubles as the zero-column preload.
        win_clr    = (state_q == IDLE) && i_start && !i_inhibit;
    end

    assign o_valid   = valid_q;
    assign o_done    = done_q;
    assign o_win_cnt = win_cnt_q;

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        logic [IMG_W-1:0] img_in;
        logic [KER_W-1:0] wgt_in;

        assign img_in = shift_zero ? '0 : i_img[IMG_ROW_OFS[r] +: IMG_W];
        assign wgt_in = shift_zero ? '0 : i_wgt[KER_ROW_OFS[r] +: KER_W];

        tap_shift3 #(.W(IMG_W)) u_img_row (
            .clk    (clk),
            .i_rst  (i_rst),
            .i_clr  (win_clr),
            .i_en   (shift_en),
            .i_d    (img_in),
            .o_taps (o_im_win[r*3*IMG_W +: 3*IMG_W])
        );

        tap_shift3 #(.W(KER_W)) u_wgt_row (
            .clk    (clk),
            .i_rst  (i_rst),
            .i_clr  (win_clr),
            .i_en   (shift_en),
            .i_d    (wgt_in),
            .o_taps (o_ker_win[r*3*KER_W +: 3*KER_W])
        );
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_conv_window_feeder
// Self-checking bench: a column-list model builds the expected windows for
// each job, a negedge monitor compares every presented window against them.
// Optional feature macro: WINDOW_ZERO_PAD_EN (must match the RTL build).
// -----------------------------------------------------------------------------
module tb_conv_window_feeder;

  localparam int IMG_W = 8;
  localparam int KER_W = 4;
  localparam int LEN_W = 17;
  localparam int WIN_W = 9*IMG_W + 9*KER_W;
`ifdef WINDOW_ZERO_PAD_EN
  localparam bit PAD_MODE = 1'b1;
`else
  localparam bit PAD_MODE = 1'b0;
`endif
  localparam int MIN_LEN = PAD_MODE ? 1 : 3;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_start = 1'b0;
  logic [LEN_W-1:0]   i_len = '0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic [23:0]        i_img = '0;
  logic [23:0]        i_wgt = '0;
  logic               i_inhibit = 1'b0;
  logic               o_valid;
  logic [9*IMG_W-1:0] o_im_win;
  logic [9*KER_W-1:0] o_ker_win;
  logic               o_busy;
  logic               o_done;
  logic [LEN_W-1:0]   o_win_cnt;

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_W(IMG_W), .KER_W(KER_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_img     (i_img),
    .i_wgt     (i_wgt),
    .i_inhibit (i_inhibit),
    .o_valid   (o_valid),
    .o_im_win  (o_im_win),
    .o_ker_win (o_ker_win),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_win_cnt (o_win_cnt)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [WIN_W-1:0] exp_q[$];
  int done_cnt = 0;
  int win_seen = 0;
  bit mon_en = 1'b0;
  bit got_first = 1'b0;
  logic [WIN_W-1:0] first_win = '0;
  logic [WIN_W-1:0] last_win = '0;
  int inhib_mode = 0;
  bit inhib_fired = 1'b0;

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Window from three columns, a = oldest; slot index = row*3 + column age.
  function automatic logic [WIN_W-1:0] make_win(input logic [23:0] ia, ib, ic,
                                                input logic [23:0] wa, wb, wc);
    logic [23:0] icol [3];
    logic [23:0] wcol [3];
    logic [9*IMG_W-1:0] im;
    logic [9*KER_W-1:0] kw;
    icol[0] = ia; icol[1] = ib; icol[2] = ic;
    wcol[0] = wa; wcol[1] = wb; wcol[2] = wc;
    im = '0;
    kw = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        im[(r*3+k)*IMG_W +: IMG_W] = icol[k][r*8 +: IMG_W];
        kw[(r*3+k)*KER_W +: KER_W] = wcol[k][r*8 +: KER_W];
      end
    end
    return {kw, im};
  endfunction

  // ---------------- inhibit driver ----------------
  int inhib_hold = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (inhib_mode)
        1: i_inhibit = ($urandom_range(0, 3) == 0);
        2: begin
          if (!inhib_fired && o_valid) begin
            inhib_fired = 1'b1;
            inhib_hold = 3;
            i_inhibit = 1'b1;
          end else if (inhib_hold > 0) begin
            inhib_hold--;
            i_inhibit = 1'b1;
          end else begin
            i_inhibit = 1'b0;
          end
        end
        default: i_inhibit = 1'b0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  bit held_valid = 1'b0;
  bit held_done = 1'b0;
  bit prev_done = 1'b0;
  initial begin
    logic [WIN_W-1:0] cur;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {o_ker_win, o_im_win};
        if (i_inhibit) check("ready_under_inhibit", o_ready, 1'b0);
        if (o_valid) begin
          if (held_valid) begin
            check("held_window", cur, last_win);
          end else if (exp_q.size() == 0) begin
            fail_now("unexpected_window", $sformatf("got window %0h want none", cur));
          end else begin
            check("window", cur, exp_q.pop_front());
            win_seen++;
            if (!got_first) first_win = cur;
            got_first = 1'b1;
            last_win = cur;
          end
        end else if (held_valid) begin
          fail_now("valid_held", "got o_valid=0 want 1 after inhibited cycle");
        end
        if (o_done) begin
          if (prev_done && !held_done)
            fail_now("done_pulse_width", "got o_done high 2 cycles want 1");
          else if (!held_done)
            done_cnt++;
        end
        held_valid = o_valid && i_inhibit;
        held_done = o_done && i_inhibit;
        prev_done = o_done;
      end
    end
  end

  // ---------------- job driver ----------------
  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_ready"}, o_ready, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_done"}, o_done, 1'b0);
    check({tag, "_win_cnt"}, o_win_cnt, '0);
    check({tag, "_windows"}, {o_ker_win, o_im_win}, '0);
  endtask

  task automatic run_job(input int len, input int gap_lo, input int gap_hi,
                         input int mode, input bit pattern, input int abort_cols);
    logic [23:0] imgs[$];
    logic [23:0] wgts[$];
    logic [23:0] ie[$];
    logic [23:0] we[$];
    int nexp;
    int ncols;
    int d0;
    int gap;
    bit ok;

    inhib_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      imgs.push_back(pattern ? {8'(3*i+3), 8'(3*i+2), 8'(3*i+1)} : 24'($urandom));
      wgts.push_back(24'($urandom));
    end
    nexp = 0;
    ncols = (len >= MIN_LEN) ? len : 0;
    if (ncols > 0) begin
      ie = imgs;
      we = wgts;
      if (PAD_MODE) begin
        ie.push_front(24'h0); ie.push_back(24'h0);
        we.push_front(24'h0); we.push_back(24'h0);
      end
      for (int k = 0; k + 2 < ie.size(); k++) begin
        exp_q.push_back(make_win(ie[k], ie[k+1], ie[k+2], we[k], we[k+1], we[k+2]));
        nexp++;
      end
    end
    win_seen = 0;
    got_first = 1'b0;
    inhib_fired = 1'b0;
    d0 = done_cnt;

    i_len = LEN_W'(len);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_len = LEN_W'($urandom);
    inhib_mode = mode;

    if (ncols == 0) begin
      @(negedge clk);
      check("short_busy", o_busy, 1'b1);
      check("short_done_early", o_done, 1'b0);
      @(negedge clk);
      check("short_done", o_done, 1'b1);
    end

    for (int i = 0; i < ncols; i++) begin
      if (abort_cols > 0 && i == abort_cols) break;
      i_valid = 1'b1;
      i_img = imgs[i];
      i_wgt = wgts[i];
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        ok = o_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) fail_now("accept_timeout", $sformatf("got no accept of column %0d want accept", i));
      i_valid = 1'b0;
      i_img = 24'($urandom);
      i_wgt = 24'($urandom);
      gap = $urandom_range(gap_lo, gap_hi);
      if (!(abort_cols > 0 && i + 1 == abort_cols)) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    if (abort_cols > 0) begin
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      check("abort_win_seen", win_seen, 1);
      check_idle_zero("abort");
      exp_q.delete();
      repeat (4) @(posedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      return;
    end

    for (int c = 0; c < 200 && done_cnt == d0; c++) @(posedge clk);
    inhib_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    check("windows_seen", win_seen, nexp);
    check("win_cnt", o_win_cnt, LEN_W'(nexp));
    check("queue_empty", exp_q.size(), 0);
    check("idle_busy", o_busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rl;
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    mon_en = 1'b1;

`ifdef WINDOW_ZERO_PAD_EN
    run_job(3, 0, 0, 0, 1'b1, 0);
    check("pad_first_window", first_win[9*IMG_W-1:0], 72'h060300050200040100);
    check("pad_last_window", last_win[9*IMG_W-1:0], 72'h000906000805000704);
    check("pad_win_cnt", o_win_cnt, 17'd3);
`else
    run_job(5, 0, 0, 0, 1'b1, 0);
    check("lit_first_window", first_win[9*IMG_W-1:0], 72'h090603080502070401);
    check("lit_last_window", last_win[9*IMG_W-1:0], 72'h0F0C090E0B080D0A07);
    check("lit_win_cnt", o_win_cnt, 17'd3);
`endif

    // Same columns with 2-cycle gaps, then with a 4-cycle stall on a window.
    run_job(5, 2, 2, 0, 1'b1, 0);
    run_job(5, 0, 0, 2, 1'b1, 0);
    check("stall_fired", inhib_fired, 1'b1);

    // Too-short job: completion pulse, no windows.
    run_job(PAD_MODE ? 0 : 2, 0, 0, 0, 1'b0, 0);

    // Reset after the first window, then a fresh 4-column job.
    run_job(5, 0, 0, 0, 1'b0, PAD_MODE ? 2 : 3);
    run_job(4, 0, 0, 0, 1'b0, 0);

    for (int j = 0; j < 8; j++) begin
      rl = $urandom_range(MIN_LEN, 12);
      run_job(rl, 0, 3, 1, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
